// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's memory stage: word RAM plus LED, timer and
// status/control registers, with zero-latency reads and a sticky bus-error flag.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] RWAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic [7:0]            Leds,
  output logic                  TimerIrq,
  output logic                  BusErr
);

  localparam int IDX_WIDTH = $clog2(RAM_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] RAM_BASE    = ADDR_WIDTH'(32'h1001_0000);
  localparam logic [ADDR_WIDTH-1:0] RAM_MASK    = ADDR_WIDTH'(4 * RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LED_ADDR    = ADDR_WIDTH'(32'h1002_0000);
  localparam logic [ADDR_WIDTH-1:0] TCNT_ADDR   = ADDR_WIDTH'(32'h1002_0004);
  localparam logic [ADDR_WIDTH-1:0] TCMP_ADDR   = ADDR_WIDTH'(32'h1002_0008);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(32'h1002_000C);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(32'h1002_0010);

  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
  logic [7:0]            ledReg;
  logic [DATA_WIDTH-1:0] tcnt;
  logic [DATA_WIDTH-1:0] tcmp;
  logic [1:0]            status;
  logic [1:0]            ctrl;

  logic                 hitRam, hitLed, hitTcnt, hitTcmp, hitStatus, hitCtrl;
  logic                 mapped, misaligned, accessOn, illegal;
  logic                 legalRead, legalWrite;
  logic                 timerMatch;
  logic [1:0]           statusSet, statusClr;
  logic [IDX_WIDTH-1:0] ramIdx;

  // The RAM window is aligned to its own size, so masking the offset bits decodes it.
  always_comb begin
    hitRam     = (RWAddress & ~RAM_MASK) == RAM_BASE;
    hitLed     = RWAddress == LED_ADDR;
    hitTcnt    = RWAddress == TCNT_ADDR;
    hitTcmp    = RWAddress == TCMP_ADDR;
    hitStatus  = RWAddress == STATUS_ADDR;
    hitCtrl    = RWAddress == CTRL_ADDR;
    mapped     = hitRam | hitLed | hitTcnt | hitTcmp | hitStatus | hitCtrl;
    misaligned = RWAddress[1:0] != 2'b00;
    accessOn   = MemRead | MemWrite;
    illegal    = accessOn & (misaligned | ~mapped | (MemRead & MemWrite));
    legalRead  = MemRead & ~illegal;
    legalWrite = MemWrite & ~illegal;
    ramIdx     = RWAddress[IDX_WIDTH+1:2];
    timerMatch = ctrl[0] & (tcnt == tcmp);
    statusSet  = {illegal, timerMatch};
    statusClr  = (legalWrite & hitStatus) ? WriteData[1:0] : 2'b00;
  end

  always_comb begin
    MemData = '0;
    if (legalRead) begin
      if (hitRam)         MemData = ram[ramIdx];
      else if (hitLed)    MemData = DATA_WIDTH'(ledReg);
      else if (hitTcnt)   MemData = tcnt;
      else if (hitTcmp)   MemData = tcmp;
      else if (hitStatus) MemData = DATA_WIDTH'(status);
      else if (hitCtrl)   MemData = DATA_WIDTH'(ctrl);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && legalWrite && hitRam) ram[ramIdx] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ledReg <= '0;
      tcnt   <= '0;
      tcmp   <= '0;
      status <= '0;
      ctrl   <= '0;
    end else begin
      if (legalWrite && hitLed)  ledReg <= WriteData[7:0];
      if (legalWrite && hitTcmp) tcmp   <= WriteData;
      if (legalWrite && hitCtrl) ctrl   <= WriteData[1:0];
      // Software writes to the counter override both increment and match wrap.
      if (legalWrite && hitTcnt) tcnt <= WriteData;
      else if (ctrl[0])          tcnt <= timerMatch ? '0 : tcnt + DATA_WIDTH'(1);
      status <= (status & ~statusClr) | statusSet;
    end
  end

  assign Leds     = ledReg;
  assign TimerIrq = status[0] & ctrl[1];
  assign BusErr   = status[1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic compared each cycle against a register-level reference model.
module tb_data_mem_responder;

  localparam logic [31:0] RAM_BASE    = 32'h1001_0000;
  localparam logic [31:0] LED_ADDR    = 32'h1002_0000;
  localparam logic [31:0] TCNT_ADDR   = 32'h1002_0004;
  localparam logic [31:0] TCMP_ADDR   = 32'h1002_0008;
  localparam logic [31:0] STATUS_ADDR = 32'h1002_000C;
  localparam logic [31:0] CTRL_ADDR   = 32'h1002_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] RWAddress, WriteData;
  logic [31:0] MemData;
  logic [7:0]  Leds;
  logic        TimerIrq, BusErr;

  data_mem_responder dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .RWAddress(RWAddress), .WriteData(WriteData), .MemData(MemData),
    .Leds(Leds), .TimerIrq(TimerIrq), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mRam [64];
  logic [7:0]  mLed;
  logic [31:0] mTcnt, mTcmp;
  logic [1:0]  mStatus, mCtrl;

  logic [31:0] lastRead;
  logic        lastIrq;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0 unmapped, 1 RAM, 2 LED, 3 TCNT, 4 TCMP, 5 STATUS, 6 CTRL
  function automatic int regionOf(input logic [31:0] a);
    if (a >= RAM_BASE && a < RAM_BASE + 32'd256) return 1;
    case (a)
      LED_ADDR:    return 2;
      TCNT_ADDR:   return 3;
      TCMP_ADDR:   return 4;
      STATUS_ADDR: return 5;
      CTRL_ADDR:   return 6;
      default:     return 0;
    endcase
  endfunction

  function automatic bit isLegal(input logic r, input logic w, input logic [31:0] a);
    return !(r && w) && (a % 4 == 0) && regionOf(a) != 0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    case (regionOf(a))
      1:       return mRam[(a - RAM_BASE) / 4];
      2:       return {24'd0, mLed};
      3:       return mTcnt;
      4:       return mTcmp;
      5:       return {30'd0, mStatus};
      6:       return {30'd0, mCtrl};
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    mLed = 0; mTcnt = 0; mTcmp = 0; mStatus = 0; mCtrl = 0;
  endtask

  task automatic modelEdge(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic rs);
    bit          ok, match, bad;
    logic [1:0]  clr;
    logic [31:0] nextTcnt;
    if (rs) begin
      modelReset();
      return;
    end
    ok = isLegal(r, w, a);
    bad = (r || w) && !ok;
    match = mCtrl[0] && (mTcnt == mTcmp);
    clr = 2'b00;
    nextTcnt = mTcnt;
    if (mCtrl[0]) nextTcnt = match ? 32'd0 : mTcnt + 32'd1;
    if (w && ok) begin
      case (regionOf(a))
        1: mRam[(a - RAM_BASE) / 4] = d;
        2: mLed = d[7:0];
        3: nextTcnt = d;
        4: mTcmp = d;
        5: clr = d[1:0];
        6: mCtrl = d[1:0];
        default: ;
      endcase
    end
    mTcnt = nextTcnt;
    mStatus = (mStatus & ~clr) | {bad, match};
  endtask

  // One bus cycle, entered and left just after a falling edge.
  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic rs);
    logic [31:0] expRead;
    rst = rs; MemRead = r; MemWrite = w; RWAddress = a; WriteData = d;
    #1;
    expRead = (r && isLegal(r, w, a)) ? modelRead(a) : 32'd0;
    checkVal("MemData", MemData, expRead);
    checkVal("Leds", {24'd0, Leds}, {24'd0, mLed});
    checkVal("TimerIrq", {31'd0, TimerIrq}, {31'd0, mStatus[0] & mCtrl[1]});
    checkVal("BusErr", {31'd0, BusErr}, {31'd0, mStatus[1]});
    lastRead = MemData;
    lastIrq = TimerIrq;
    @(posedge clk);
    modelEdge(r, w, a, d, rs);
    @(negedge clk);
  endtask

  function automatic logic [31:0] randAddr();
    int pick;
    pick = $urandom_range(0, 11);
    case (pick)
      0, 1, 2: return RAM_BASE + 32'($urandom_range(0, 63)) * 4;
      3:       return RAM_BASE + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      4:       return LED_ADDR;
      5:       return TCNT_ADDR;
      6:       return TCMP_ADDR;
      7:       return STATUS_ADDR;
      8:       return CTRL_ADDR;
      9:       return ($urandom_range(0, 1) == 0) ? RAM_BASE + 32'd256 : RAM_BASE - 32'd4;
      10:      return 32'h1002_0014;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  function automatic logic [31:0] randData(input logic [31:0] a);
    if (a == TCMP_ADDR) return 32'($urandom_range(0, 12));
    if (a == TCNT_ADDR) begin
      if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFF;
      return 32'($urandom_range(0, 12));
    end
    return $urandom;
  endfunction

  initial begin
    logic r, w, rs;
    logic [31:0] a, d;
    int op;

    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; RWAddress = '0; WriteData = '0;
    @(posedge clk);
    @(posedge clk);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    checkVal("rstLeds", {24'd0, Leds}, 32'd0);
    checkVal("rstIrq", {31'd0, TimerIrq}, 32'd0);
    checkVal("rstBusErr", {31'd0, BusErr}, 32'd0);

    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, RAM_BASE + 32'(i) * 4, $urandom, 1'b0);
    cyc(1'b1, 1'b0, TCNT_ADDR, 32'd0, 1'b0);
    checkVal("rstTcnt", lastRead, 32'd0);

    // Store then load-next-cycle
    cyc(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0);
    cyc(1'b1, 1'b0, 32'h1001_0008, 32'd0, 1'b0);
    checkVal("ramReadBack", lastRead, 32'hDEAD_BEEF);
    checkVal("ramBusErr", {31'd0, BusErr}, 32'd0);

    // Timer count sequence and match interrupt
    cyc(1'b0, 1'b1, TCMP_ADDR, 32'd3, 1'b0);
    cyc(1'b0, 1'b1, CTRL_ADDR, 32'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, TCNT_ADDR, 32'd0, 1'b0);
      checkVal("tcntSeq", lastRead, 32'(i));
      checkVal("irqBeforeMatch", {31'd0, lastIrq}, 32'd0);
    end
    cyc(1'b1, 1'b0, TCNT_ADDR, 32'd0, 1'b0);
    checkVal("tcntWrap", lastRead, 32'd0);
    checkVal("irqAfterMatch", {31'd0, lastIrq}, 32'd1);

    // W1C colliding with a new match: set wins
    cyc(1'b0, 1'b1, STATUS_ADDR, 32'd1, 1'b0);
    cyc(1'b1, 1'b0, STATUS_ADDR, 32'd0, 1'b0);
    checkVal("statusCleared", lastRead, 32'd0);
    cyc(1'b0, 1'b1, STATUS_ADDR, 32'd1, 1'b0);
    cyc(1'b1, 1'b0, STATUS_ADDR, 32'd0, 1'b0);
    checkVal("setWinsW1c", lastRead, 32'd1);

    cyc(1'b0, 1'b1, CTRL_ADDR, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, STATUS_ADDR, 32'd3, 1'b0);

    // Misaligned read, then W1C of the bus-error bit
    cyc(1'b1, 1'b0, 32'h1001_0002, 32'd0, 1'b0);
    checkVal("misalignData", lastRead, 32'd0);
    checkVal("misalignBusErr", {31'd0, BusErr}, 32'd1);
    cyc(1'b0, 1'b1, STATUS_ADDR, 32'd2, 1'b0);
    checkVal("busErrCleared", {31'd0, BusErr}, 32'd0);

    // Simultaneous read and write is illegal
    cyc(1'b1, 1'b1, LED_ADDR, 32'hFF, 1'b0);
    checkVal("rwLedsUnchanged", {24'd0, Leds}, 32'd0);
    checkVal("rwBusErr", {31'd0, BusErr}, 32'd1);
    cyc(1'b0, 1'b1, STATUS_ADDR, 32'd3, 1'b0);

    // Reset pulse while timer runs
    cyc(1'b0, 1'b1, LED_ADDR, 32'h5A, 1'b0);
    cyc(1'b0, 1'b1, CTRL_ADDR, 32'd3, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checkVal("ledsBeforeRst", {24'd0, Leds}, 32'h5A);
    cyc(1'b0, 1'b1, LED_ADDR, 32'hFF, 1'b1);
    checkVal("rstPulseLeds", {24'd0, Leds}, 32'd0);
    checkVal("rstPulseIrq", {31'd0, TimerIrq}, 32'd0);
    cyc(1'b1, 1'b0, TCNT_ADDR, 32'd0, 1'b0);
    checkVal("rstTcntA", lastRead, 32'd0);
    cyc(1'b1, 1'b0, TCNT_ADDR, 32'd0, 1'b0);
    checkVal("rstTcntHold", lastRead, 32'd0);
    cyc(1'b1, 1'b0, 32'h1001_0008, 32'd0, 1'b0);
    checkVal("ramSurvivesRst", lastRead, 32'hDEAD_BEEF);

    // Modulo wrap of the counter
    cyc(1'b0, 1'b1, TCMP_ADDR, 32'd5, 1'b0);
    cyc(1'b0, 1'b1, CTRL_ADDR, 32'd1, 1'b0);
    cyc(1'b0, 1'b1, TCNT_ADDR, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b1, 1'b0, TCNT_ADDR, 32'd0, 1'b0);
    checkVal("tcntMax", lastRead, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, TCNT_ADDR, 32'd0, 1'b0);
    checkVal("tcntModWrap", lastRead, 32'd0);

    for (int n = 0; n < 4000; n++) begin
      a = randAddr();
      d = randData(a);
      op = $urandom_range(0, 99);
      r = (op >= 20 && op < 60) || op >= 95;
      w = (op >= 60);
      rs = ($urandom_range(0, 199) == 0);
      cyc(r, w, a, d, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning address bus width.
REQ-003 SHALL have parameter RAM_DEPTH, default 64, meaning number of RAM words (power of 2).
REQ-004 SHALL have port clk  input  1  system clock; one clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port MemRead  input  1  read strobe from core memory stage.
REQ-007 SHALL have port MemWrite  input  1  write strobe from core memory stage.
REQ-008 SHALL have port RWAddress  input  ADDR_WIDTH  byte address, word accesses only.
REQ-009 SHALL have port WriteData  input  DATA_WIDTH  store data.
REQ-010 SHALL have port MemData  output  DATA_WIDTH  load data returned to core.
REQ-011 SHALL have port Leds  output  8  LED register contents.
REQ-012 SHALL have port TimerIrq  output  1  timer interrupt request, level.
REQ-013 SHALL have port BusErr  output  1  sticky bus-error flag.

Function
REQ-014 SHALL decode map: RAM 0x1001_0000..0x1001_0000+4*RAM_DEPTH-1; LED 0x1002_0000; TCNT 0x1002_0004; TCMP 0x1002_0008; STATUS 0x1002_000C; CTRL 0x1002_0010; all else unmapped.
REQ-015 SHALL return MemData combinationally in the same cycle MemRead is high (zero-cycle read latency); MemData = 0 when MemRead low.
REQ-016 SHALL commit writes at the rising edge of the cycle in which MemWrite is high; a read of the same address in the next cycle returns the new value.
REQ-017 SHALL treat access as illegal when: RWAddress[1:0] != 0, address unmapped, or MemRead and MemWrite both high; illegal access performs no write, returns MemData = 0, sets STATUS[1] at the next edge.
REQ-018 SHALL hold LED in bits [7:0] of LED register; reads return zero-extended value; writes take WriteData[7:0].
REQ-019 SHALL use CTRL bit0 = timer enable, bit1 = irq enable; other bits read 0.
REQ-020 SHALL increment TCNT by 1 each cycle while CTRL[0]=1; when TCNT == TCMP and CTRL[0]=1, TCNT becomes 0 at the next edge and STATUS[0] sets.
REQ-021 SHALL give a write to TCNT priority over increment and wrap in the same cycle; TCNT wraps 0xFFFF_FFFF -> 0 by modulo arithmetic.
REQ-022 SHALL clear STATUS bits by writing 1 to them (W1C); if set and clear coincide in one cycle, set wins.
REQ-023 SHALL drive TimerIrq = STATUS[0] & CTRL[1]; BusErr = STATUS[1]; both registered, no combinational path from inputs.
REQ-024 SHALL use RAM index RWAddress[log2(RAM_DEPTH)+1:2] within the RAM window.

Reset
REQ-025 SHALL, on rst high at a rising edge, clear LED, TCNT, TCMP, STATUS, CTRL to 0; Leds, TimerIrq, BusErr = 0 the following cycle.
REQ-026 SHALL ignore MemWrite during a reset cycle; RAM contents are not cleared by reset.
REQ-027 SHALL, if rst asserts while the timer runs, stop counting and clear pending match; operation resumes only after software re-enables CTRL[0].

Verification
REQ-028 SHALL cover: write 0xDEADBEEF to 0x1001_0008, read next cycle -> MemData = 0xDEADBEEF, BusErr stays 0.
REQ-029 SHALL cover: TCMP=3, CTRL=0x3 -> TCNT reads 0,1,2,3 then 0; STATUS[0]=1 and TimerIrq=1 one cycle after TCNT==3.
REQ-030 SHALL cover: read 0x1001_0002 (misaligned) -> MemData = 0; BusErr=1 next cycle; write 0x2 to STATUS -> BusErr=0 next cycle.
REQ-031 SHALL cover: MemRead=MemWrite=1 to 0x1002_0000 with WriteData=0xFF -> Leds unchanged (0x00), BusErr=1.
REQ-032 SHALL cover: W1C of STATUS[0] in the same cycle as a new TCNT==TCMP match -> STATUS[0] remains 1.
REQ-033 SHALL cover: timer running with Leds=0x5A, rst pulsed one cycle -> Leds=0, TCNT=0 holding, TimerIrq=0, RAM word previously written still reads back intact.
